uart_word_packer: RTL and testbench



---
 rtl/uart_word_packer_if.sv | 36 +++
 rtl/uart_word_packer.sv | 175 +++++++++++++++++
 tb/tb_uart_word_packer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_packer_if.sv
// rtl/uart_word_packer_if.sv - byte-in / word-write / frame-status bundle for uart_word_packer
// err_checksum exists only when PACK_CHECKSUM_EN is defined.
interface uart_word_packer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              frame_ack;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data;
  logic              frame_done;
  logic              frame_ready;
  logic              byte_drop;
  logic              err_timeout;
`ifdef PACK_CHECKSUM_EN
  logic              err_checksum;
`endif

  modport slave (
    input  rx_data, rx_valid, frame_ack,
`ifdef PACK_CHECKSUM_EN
    output err_checksum,
`endif
    output buf_wr_en, buf_wr_addr, buf_wr_data, frame_done, frame_ready, byte_drop, err_timeout
  );

  modport master (
    output rx_data, rx_valid, frame_ack,
`ifdef PACK_CHECKSUM_EN
    input  err_checksum,
`endif
    input  buf_wr_en, buf_wr_addr, buf_wr_data, frame_done, frame_ready, byte_drop, err_timeout
  );
endinterface

// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - packs UART bytes MSB-first into a WORDS-word frame in the input buffer
// Optional trailing checksum byte enabled by PACK_CHECKSUM_EN.
module uart_word_packer #(
  parameter int WORDS       = 96,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic               sys_clk,
  input logic               rst,
  uart_word_packer_if.slave bus
);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

`ifdef PACK_CHECKSUM_EN
  typedef enum logic [1:0] {S_HI, S_LO, S_FULL, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_HI, S_LO, S_FULL} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        msb_q, msb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              drop_q, drop_d;
  logic              tout_q, tout_d;
  logic              last_word, cnt_run;
`ifdef PACK_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              chk_err_q, chk_err_d;
`endif

  assign last_word = (idx_q == ADDR_W'(WORDS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    msb_d     = msb_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
    drop_d    = 1'b0;
    tout_d    = 1'b0;
    cnt_run   = (state_q == S_LO) || ((state_q == S_HI) && (idx_q != '0));
`ifdef PACK_CHECKSUM_EN
    chk_err_d = 1'b0;
    sum_d     = sum_q;
    cnt_run   = cnt_run || (state_q == S_CHK);
    // First MSB of a frame restarts the running sum.
    if (bus.rx_valid && (state_q == S_HI || state_q == S_LO))
      sum_d = (state_q == S_HI && idx_q == '0) ? bus.rx_data : sum_q + bus.rx_data;
`endif

    case (state_q)
      S_HI: begin
        if (bus.rx_valid) begin
          msb_d   = bus.rx_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (bus.rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = {msb_q, bus.rx_data};
          if (last_word) begin
            idx_d = '0;
`ifdef PACK_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_FULL;
            done_d  = 1'b1;
            ready_d = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_HI;
          end
        end
      end
      S_FULL: begin
        if (bus.rx_valid) drop_d = 1'b1;
        if (bus.frame_ack) begin
          ready_d = 1'b0;
          state_d = S_HI;
        end
      end
`ifdef PACK_CHECKSUM_EN
      S_CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_q) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_FULL;
          end else begin
            chk_err_d = 1'b1;
            state_d   = S_HI;
          end
        end
      end
`endif
      default: state_d = S_HI;
    endcase

    // A byte arriving in the terminal cycle wins over the timeout.
    if (!cnt_run || bus.rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      cnt_d   = '0;
      tout_d  = 1'b1;
      idx_d   = '0;
      state_d = S_HI;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= S_HI;
      idx_q     <= '0;
      msb_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      drop_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      msb_q     <= msb_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      drop_q    <= drop_d;
      tout_q    <= tout_d;
    end
  end

`ifdef PACK_CHECKSUM_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sum_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign bus.err_checksum = chk_err_q;
`endif

  assign bus.buf_wr_en   = wr_en_q;
  assign bus.buf_wr_addr = wr_addr_q;
  assign bus.buf_wr_data = wr_data_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_ready = ready_q;
  assign bus.byte_drop   = drop_q;
  assign bus.err_timeout = tout_q;
endmodule

// File: tb/tb_uart_word_packer.sv
// tb/tb_uart_word_packer.sv - scoreboard bench for uart_word_packer (PACK_CHECKSUM_EN optional)
`timescale 1ns/1ps
module tb_uart_word_packer;
  localparam int WORDS = 96;
  localparam int TOUT  = 1000;
`ifdef PACK_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic        en;
    logic [6:0]  addr;
    logic [15:0] data;
    logic        done, ready, drop, tout, chk;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  ev_t  exp_q[$];
  logic chk_w;

  uart_word_packer_if #(.ADDR_W(7), .DATA_W(16)) bus ();

  uart_word_packer #(.WORDS(WORDS), .DATA_W(16), .ADDR_W(7), .TIMEOUT_CYC(TOUT)) dut (
    .sys_clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef PACK_CHECKSUM_EN
  assign chk_w = bus.err_checksum;
`else
  assign chk_w = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit at cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic ev_t mk(input int c, input logic en, input logic [6:0] a, input logic [15:0] d,
                             input logic done, input logic ready, input logic drop,
                             input logic tout, input logic chk);
    ev_t e;
    e.cyc = c; e.en = en; e.addr = a; e.data = d;
    e.done = done; e.ready = ready; e.drop = drop; e.tout = tout; e.chk = chk;
    return e;
  endfunction

  // Monitor: every cycle that shows any strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (bus.buf_wr_en || bus.frame_done || bus.byte_drop || bus.err_timeout || chk_w)) begin
      ev_t e;
      bit  ok;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: cyc=%0d en=%0b addr=%0d data=%h done=%0b drop=%0b tout=%0b chk=%0b, required none",
                 cyc, bus.buf_wr_en, bus.buf_wr_addr, bus.buf_wr_data, bus.frame_done,
                 bus.byte_drop, bus.err_timeout, chk_w);
      end else begin
        e  = exp_q.pop_front();
        ok = (e.cyc == cyc) && (e.en == bus.buf_wr_en) && (e.done == bus.frame_done) &&
             (e.ready == bus.frame_ready) && (e.drop == bus.byte_drop) &&
             (e.tout == bus.err_timeout) && (e.chk == chk_w) &&
             (!e.en || (e.addr == bus.buf_wr_addr && e.data == bus.buf_wr_data));
        if (ok) passes++;
        else $display("FAIL event: got cyc=%0d en=%0b addr=%0d data=%h done=%0b rdy=%0b drop=%0b tout=%0b chk=%0b, required cyc=%0d en=%0b addr=%0d data=%h done=%0b rdy=%0b drop=%0b tout=%0b chk=%0b",
                      cyc, bus.buf_wr_en, bus.buf_wr_addr, bus.buf_wr_data, bus.frame_done,
                      bus.frame_ready, bus.byte_drop, bus.err_timeout, chk_w,
                      e.cyc, e.en, e.addr, e.data, e.done, e.ready, e.drop, e.tout, e.chk);
      end
    end
  end

  // Called at posedge+1; returns with the byte sampled and c = cycle whose outputs respond.
  task automatic send_byte(input logic [7:0] b, input logic ack, output int c);
    bus.rx_data = b; bus.rx_valid = 1'b1; bus.frame_ack = ack;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.frame_ack = 1'b0;
    c = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_ack();
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic [6:0] a, input logic last, output int c);
    send_byte(w[15:8], 1'b0, c);
    send_byte(w[7:0], 1'b0, c);
    exp_q.push_back(mk(c, 1'b1, a, w, last && !CHK, last && !CHK, 1'b0, 1'b0, 1'b0));
  endtask

  // mode 0: word k = 0x0100+k ; mode 1: all bytes 0x01. bad adds to the checksum byte.
  task automatic send_frame(input int mode, input logic [7:0] bad);
    int         c;
    logic [7:0] sum = 8'h00;
    logic [15:0] w;
    for (int k = 0; k < WORDS; k++) begin
      w = (mode == 0) ? 16'(16'h0100 + k) : 16'h0101;
      sum = sum + w[15:8] + w[7:0];
      send_word(w, 7'(k), k == WORDS - 1, c);
    end
    if (CHK) begin
      send_byte(sum + bad, 1'b0, c);
      if (bad == 8'h00) exp_q.push_back(mk(c, 1'b0, 7'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      else              exp_q.push_back(mk(c, 1'b0, 7'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  initial begin
    int c, c0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.frame_ack = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("reset_wr_en", 32'(bus.buf_wr_en), 32'd0);
    check("reset_wr_addr", 32'(bus.buf_wr_addr), 32'd0);
    check("reset_wr_data", 32'(bus.buf_wr_data), 32'd0);
    check("reset_frame_done", 32'(bus.frame_done), 32'd0);
    check("reset_frame_ready", 32'(bus.frame_ready), 32'd0);
    check("reset_byte_drop", 32'(bus.byte_drop), 32'd0);
    check("reset_err_timeout", 32'(bus.err_timeout), 32'd0);

    // Full frame, then drops while held; third byte arrives with the ack.
    send_frame(0, 8'h00);
    idle(2);
    check("frame_ready_held", 32'(bus.frame_ready), 32'd1);
    send_byte(8'hEE, 1'b0, c);
    exp_q.push_back(mk(c, 1'b0, 7'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    send_byte(8'hEF, 1'b0, c);
    exp_q.push_back(mk(c, 1'b0, 7'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    send_byte(8'hF0, 1'b1, c);
    exp_q.push_back(mk(c, 1'b0, 7'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    check("frame_ready_after_ack", 32'(bus.frame_ready), 32'd0);

    // Ack outside S_FULL is ignored; 11 bytes then timeout.
    pulse_ack();
    for (int k = 0; k < 5; k++) send_word(16'(16'hA000 + k), 7'(k), 1'b0, c);
    send_byte(8'h99, 1'b0, c);
    exp_q.push_back(mk(c + TOUT, 1'b0, 7'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    idle(TOUT + 5);
    check("ready_after_timeout", 32'(bus.frame_ready), 32'd0);
    send_frame(0, 8'h00);
    idle(1);
    check("frame_ready_frame2", 32'(bus.frame_ready), 32'd1);
    pulse_ack();
    check("frame_ready_ack2", 32'(bus.frame_ready), 32'd0);

`ifdef PACK_CHECKSUM_EN
    send_frame(1, 8'h00);
    idle(1);
    check("chk_match_ready", 32'(bus.frame_ready), 32'd1);
    pulse_ack();
    send_frame(1, 8'h01);
    idle(1);
    check("chk_mismatch_ready", 32'(bus.frame_ready), 32'd0);
`endif

    // LSB lands exactly in the terminal timeout cycle.
    send_byte(8'h5A, 1'b0, c0);
    idle(TOUT - 1);
    send_byte(8'hA5, 1'b0, c);
    exp_q.push_back(mk(c, 1'b1, 7'd0, 16'h5AA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    check("terminal_cycle_offset", 32'(c - c0), 32'(TOUT));

    // Reset right after an MSB: next two bytes form word 0.
    send_byte(8'h77, 1'b0, c);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midreset_wr_en", 32'(bus.buf_wr_en), 32'd0);
    check("midreset_ready", 32'(bus.frame_ready), 32'd0);
    send_word(16'h1234, 7'd0, 1'b0, c);
    idle(10);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
